// File: rtl/alu_result_display.sv
// ALU result display: double-dabble binary-to-BCD conversion of a
// 12-bit result word driving a scanned 5-digit seven-segment display.
module alu_result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] data_i,
  input  logic        load_i,
  input  logic        signed_i,
  output logic        busy_o,
  output logic [6:0]  seg_o,
  output logic [4:0]  an_o
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_data;
  logic        r_sgn;
  logic [11:0] r_mag;
  logic        r_neg;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [15:0] r_disp;
  logic        r_disp_neg;
  logic [CW-1:0] r_scan;
  logic [2:0]  r_idx;
  logic [6:0]  r_seg;
  logic [4:0]  r_an;

  logic        w_neg;
  logic [15:0] w_adj;
  logic [3:0]  w_dig;
  logic        w_blank;
  logic [6:0]  w_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign busy_o = (r_state != IDLE);
  assign w_neg  = r_sgn & r_data[11];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                        r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (load_i) w_next = ABS;
      ABS:     w_next = SHIFT;
      SHIFT:   if (r_cnt == 4'd11) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data     <= '0;
      r_sgn      <= 1'b0;
      r_mag      <= '0;
      r_neg      <= 1'b0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_disp_neg <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load_i) begin
            r_data <= data_i;
            r_sgn  <= signed_i;
          end
        end
        ABS: begin
          r_neg <= w_neg;
          r_mag <= w_neg ? (~r_data + 12'd1) : r_data;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_bcd <= {w_adj[14:0], r_mag[11]};
          r_mag <= {r_mag[10:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        DONE: begin
          r_disp     <= r_bcd;
          r_disp_neg <= r_neg;
        end
        default: ;
      endcase
    end
  end

  // Upper digits blank while they and every higher digit are zero.
  always_comb begin
    w_dig   = r_disp[3:0];
    w_blank = 1'b0;
    w_seg   = SEG_BLANK;
    unique case (r_idx)
      3'd0: w_dig = r_disp[3:0];
      3'd1: begin
        w_dig   = r_disp[7:4];
        w_blank = (r_disp[15:4] == 12'd0);
      end
      3'd2: begin
        w_dig   = r_disp[11:8];
        w_blank = (r_disp[15:8] == 8'd0);
      end
      3'd3: begin
        w_dig   = r_disp[15:12];
        w_blank = (r_disp[15:12] == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase
    if (r_idx == 3'd4)
      w_seg = r_disp_neg ? SEG_MINUS : SEG_BLANK;
    else if (w_blank)
      w_seg = SEG_BLANK;
    else
      w_seg = f_seg(w_dig);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_an   <= 5'b11110;
      r_seg  <= 7'b1000000;
    end else begin
      if (r_scan == SCAN_LAST) begin
        r_scan <= '0;
        r_idx  <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_scan <= r_scan + CW'(1);
      end
      r_an  <= ~(5'b00001 << r_idx);
      r_seg <= w_seg;
    end
  end

  assign seg_o = r_seg;
  assign an_o  = r_an;

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: directed and random conversions checked
// against an integer-arithmetic model of the expected display.
module tb_alu_result_display;

  logic        clk_i;
  logic        rst_i;
  logic [11:0] data_i;
  logic        load_i;
  logic        signed_i;
  logic        busy_o;
  logic [6:0]  seg_o;
  logic [4:0]  an_o;

  int n_pass;
  int n_total;
  logic [6:0] exp_seg [5];

  localparam logic [6:0] BLANK = 7'b1111111;

  alu_result_display #(.SCAN_DIV(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .load_i   (load_i),
    .signed_i (signed_i),
    .busy_o   (busy_o),
    .seg_o    (seg_o),
    .an_o     (an_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] seg7(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  task automatic model(input logic [11:0] d, input logic s);
    int v;
    int m;
    bit neg;
    v = s ? int'($signed(d)) : int'(d);
    neg = (v < 0);
    m = neg ? -v : v;
    exp_seg[0] = seg7(m % 10);
    exp_seg[1] = (m >= 10)   ? seg7((m / 10) % 10)   : BLANK;
    exp_seg[2] = (m >= 100)  ? seg7((m / 100) % 10)  : BLANK;
    exp_seg[3] = (m >= 1000) ? seg7((m / 1000) % 10) : BLANK;
    exp_seg[4] = neg ? 7'b0111111 : BLANK;
  endtask

  task automatic check_display(input string name);
    int idx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      idx = -1;
      for (int k = 0; k < 5; k++)
        if (an_o == ~(5'b00001 << k)) idx = k;
      n_total++;
      if (idx < 0) begin
        $display("FAIL %s an_o not one-hot: got %b", name, an_o);
      end else if (seg_o !== exp_seg[idx]) begin
        $display("FAIL %s digit%0d seg: got %b want %b",
                 name, idx, seg_o, exp_seg[idx]);
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic start_load(input logic [11:0] d, input logic s);
    @(negedge clk_i);
    data_i   = d;
    signed_i = s;
    load_i   = 1'b1;
    @(negedge clk_i);
    load_i   = 1'b0;
    data_i   = $urandom;
    signed_i = $urandom;
  endtask

  task automatic test_reset();
    logic [4:0] prev;
    logic [4:0] want;
    int run;
    int idx;
    bit first;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_total++;
    if (busy_o !== 1'b0 || an_o !== 5'b11110 || seg_o !== 7'b1000000)
      $display("FAIL reset_state: busy=%b an=%b seg=%b want 0 11110 1000000",
               busy_o, an_o, seg_o);
    else n_pass++;
    rst_i = 1'b0;
    prev  = an_o;
    run   = 1;
    first = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk_i);
      if (an_o === prev) begin
        run++;
      end else begin
        idx = 0;
        for (int k = 0; k < 5; k++)
          if (prev == ~(5'b00001 << k)) idx = k;
        want = ~(5'b00001 << ((idx + 1) % 5));
        n_total++;
        if (an_o !== want || (!first && run != 4))
          $display("FAIL scan_step: an=%b want %b run=%0d want 4",
                   an_o, want, run);
        else n_pass++;
        first = 1'b0;
        prev  = an_o;
        run   = 1;
      end
    end
    model(12'd0, 1'b0);
    check_display("reset_display");
  endtask

  task automatic test_convert(input logic [11:0] d, input logic s,
                              input string name);
    logic want;
    @(negedge clk_i);
    data_i   = d;
    signed_i = s;
    load_i   = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_i);
      if (i == 1) begin
        load_i   = 1'b0;
        data_i   = $urandom;
        signed_i = $urandom;
      end
      want = (i <= 14);
      n_total++;
      if (busy_o !== want)
        $display("FAIL %s busy cycle N+%0d: got %b want %b",
                 name, i, busy_o, want);
      else n_pass++;
    end
    model(d, s);
    check_display(name);
  endtask

  task automatic test_random();
    logic [11:0] d;
    logic s;
    for (int r = 0; r < 8; r++) begin
      d = 12'($urandom);
      s = 1'($urandom);
      start_load(d, s);
      repeat (16) @(negedge clk_i);
      model(d, s);
      check_display("random");
    end
  endtask

  task automatic test_drop_and_reset();
    start_load(12'd7, 1'b0);
    repeat (3) @(negedge clk_i);
    data_i = 12'd99;
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (14) @(negedge clk_i);
    model(12'd7, 1'b0);
    check_display("drop_busy_load");
    start_load(12'd1234, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (busy_o !== 1'b0 || an_o !== 5'b11110 || seg_o !== 7'b1000000)
      $display("FAIL abort_reset: busy=%b an=%b seg=%b want 0 11110 1000000",
               busy_o, an_o, seg_o);
    else n_pass++;
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    n_total++;
    if (busy_o !== 1'b0)
      $display("FAIL abort_stays_idle: busy=%b want 0", busy_o);
    else n_pass++;
    model(12'd0, 1'b0);
    check_display("abort_display");
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_i    = 1'b1;
    data_i   = '0;
    load_i   = 1'b0;
    signed_i = 1'b0;
    test_reset();
    test_convert(12'd1234, 1'b0, "u1234");
    test_convert(12'hFFB, 1'b1, "s_minus5");
    test_convert(12'h800, 1'b1, "s_minus2048");
    test_convert(12'h800, 1'b0, "u2048");
    test_convert(12'hFFF, 1'b0, "u4095");
    test_convert(12'h7FF, 1'b1, "s2047");
    test_convert(12'd0, 1'b1, "s_zero");
    test_random();
    test_drop_and_reset();
    test_convert(12'd305, 1'b0, "after_reset");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
